// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift/compare ops plus an iterative
// shift-add multiplier and restoring divider behind one IDLE/BUSY/DONE controller.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_REMU  = 4'b1101,
        OP_DIV   = 4'b1110,
        OP_REM   = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    function automatic logic [WIDTH-1:0] single_op(input op_e op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return WIDTH'($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    state_e             state, state_nx;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               accept;
    logic               step;
    logic               last;
    logic               req_multi;
    logic               req_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   multi_result;

    assign req_multi  = (alu_control >= OP_MUL);
    assign req_signed = (alu_control == OP_DIV) || (alu_control == OP_REM);
    assign a_neg      = req_signed & src1[WIDTH-1];
    assign b_neg      = req_signed & src2[WIDTH-1];
    assign a_mag      = a_neg ? -src1 : src1;
    assign b_mag      = b_neg ? -src2 : src2;
    assign last       = (cnt == '0);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = req_multi ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                step = 1'b1;
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Multiplier: add the multiplicand into the top half when the LSB is set, then shift right.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {mul_sum, prod[WIDTH-1:1]};

    // Divider: shift the next dividend bit into the partial remainder and try a subtract.
    assign div_trial = {rem, quo[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, divisor};
    assign div_ge    = ~div_diff[WIDTH];
    assign rem_step  = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign quo_step  = {quo[WIDTH-2:0], div_ge};

    always_comb begin
        multi_result = '0;
        case (op_q)
            OP_MUL:   multi_result = prod_step[WIDTH-1:0];
            OP_MULHU: multi_result = prod_step[2*WIDTH-1:WIDTH];
            OP_DIVU:  multi_result = div_zero ? '1 : quo_step;
            OP_REMU:  multi_result = rem_step;
            OP_DIV:   multi_result = div_zero ? '1 : (neg_q ? -quo_step : quo_step);
            OP_REM:   multi_result = neg_r ? -rem_step : rem_step;
            default:  multi_result = '0;
        endcase
    end

    // NOTE: state lives in always_ff with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= op_e'(alu_control);
                cnt  <= CNT_W'(WIDTH - 1);
                if (!req_multi) result_q <= single_op(op_e'(alu_control), src1, src2);
            end else if (step) begin
                cnt <= cnt - CNT_W'(1);
                if (last) result_q <= multi_result;
            end
        end
    end

    // NOTE: iteration registers are reloaded on every accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand    <= src1;
            prod     <= {{WIDTH{1'b0}}, src2};
            divisor  <= b_mag;
            quo      <= a_mag;
            rem      <= '0;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (src2 == '0);
        end else if (step) begin
            prod <= prod_step;
            quo  <= quo_step;
            rem  <= rem_step;
        end
    end

    assign alu_result = result_q;
    assign zero       = (result_q == '0);

endmodule
